rot_sequencer: RTL and testbench
================================

Name: rot_sequencer

Overview:
- Command-driven controller for a load/rotate register (sub-module rot_reg) that has no hold encoding.
- Accepts one command at a time over a valid/ready handshake: load a word, then rotate it left or right a programmed number of steps.
- Returns the result over a second valid/ready handshake.
- Sits between a host/bus-side requester and the rotate register, and owns that register's control pins.

Parameters:
- DATA_WIDTH, 4, width of rotated word (>=2).
- AMT_WIDTH, 3, width of step-count field; max steps 2^AMT_WIDTH-1.

Ports:
- clk  input  1  clock, rising edge.
- n_rst  input  1  asynchronous reset, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept command.
- cmd_dir  input  1  0 = rotate left, 1 = rotate right.
- cmd_amount  input  AMT_WIDTH  number of single-bit rotate steps.
- cmd_data  input  DATA_WIDTH  word to load.
- abort  input  1  synchronous; terminate rotation early.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- res_data  output  DATA_WIDTH  rotated word.
- busy  output  1  high in any state except IDLE.
- rot_left  output  1  to rot_reg left-rotate control.
- rot_right  output  1  to rot_reg right-rotate control.
- rot_data  output  DATA_WIDTH  to rot_reg load data.
- rot_q  input  DATA_WIDTH  rot_reg current value.

Behaviour:
- rot_reg encoding per clock: {right,left} = 00 or 11 loads rot_data; 01 rotates left (MSB to LSB); 10 rotates right (LSB to MSB). It has no hold.
- Hold is produced by driving 00 with rot_data = rot_q (feedback load).
- States are IDLE, LOAD, ROTATE, DONE; encoding comes from the shared package.
- IDLE:
  - cmd_ready=1; rot pins = hold.
  - On cmd_valid&&cmd_ready: latch dir, amount and data into registers; go to LOAD.
- LOAD:
  - cmd_ready=0; rot_left=rot_right=0; rot_data = latched data.
  - Next state: ROTATE with step counter = amount if amount!=0, else DONE.
- ROTATE:
  - Drive rot_left=1 (dir 0) or rot_right=1 (dir 1); decrement counter each cycle.
  - Counter reaching 1 -> DONE after this edge, so exactly amount rotate edges occur.
- DONE:
  - res_valid=1; res_data = rot_q; rot pins = hold.
  - On res_ready: go to IDLE.
  - res_data stays stable while res_valid && !res_ready.
- Latency: command accepted at edge k gives res_valid high after edge k+1+amount. amount=0 gives k+1.
- Throughput: at best one command per amount+3 cycles; no command is accepted in DONE.
- abort:
  - Sampled only in ROTATE. If high, no rotate that cycle (hold driven) and next state is DONE.
  - Result is the partially rotated word.
  - Ignored in IDLE, LOAD and DONE.
- Amount >= DATA_WIDTH is executed literally, with no modulo reduction. amount=DATA_WIDTH returns the original word.
- Reset: state IDLE; counter, latched dir, latched amount and latched data are 0.
- Reset values of outputs: cmd_ready=1, res_valid=0, busy=0, rot_left=0, rot_right=0; rot_data=rot_q and res_data=rot_q (both 0 during reset).
- Reset mid-operation: returns to IDLE immediately; the in-flight command is discarded and no result is produced.
- Outputs rot_left, rot_right, rot_data, res_data, cmd_ready, res_valid and busy are combinational from state and registers only. There is no combinational path from cmd_* to rot_*.

Decomposition:
- Shared package rot_pkg holds:
  - state typedef (IDLE/LOAD/ROTATE/DONE);
  - direction constants DIR_LEFT=0, DIR_RIGHT=1;
  - rot_reg control encodings (LOAD=2'b00, ROT_L=2'b01, ROT_R=2'b10).
- rot_sequencer instantiates no datapath.
- The natural sub-module is rot_reg (the load/rotate register). The bench pairs the two in a wrapper rot_unit for end-to-end checks.

Test Plan:
- DATA_WIDTH=4: cmd data=4'b1001, dir=L, amount=1 at edge k -> res_valid after edge k+2, res_data=4'b0011.
- data=4'b1001, dir=R, amount=3 -> rot_q sequence 1001,1100,0110,0011; res_data=4'b0011 after edge k+4.
- data=4'b1011, dir=L, amount=4 -> res_data=4'b1011 after edge k+5. Also amount=0, data=4'b0110 -> res_data=4'b0110 after edge k+1.
- Backpressure: res_ready low for 3 cycles in DONE -> res_data and rot_q hold 4'b0011, cmd_ready=0 throughout, and a cmd_valid pulse is not accepted. res_ready=1 -> IDLE and cmd_ready=1 next cycle.
- Abort: data=4'b0001, dir=L, amount=5; abort high in the 3rd ROTATE cycle -> exactly 2 rotates, res_data=4'b0100.
- Reset: n_rst low mid-ROTATE -> asynchronously IDLE, busy=0, res_valid=0, rot pins 00. After release, a new command completes correctly.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared state encoding, direction codes and rot_reg control encodings
// used by the rotate sequencer and the rotate register it drives.
package rot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ROTATE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // {right, left} pin pairs understood by rot_reg; 2'b11 also loads.
    localparam logic [1:0] CTRL_LOAD  = 2'b00;
    localparam logic [1:0] CTRL_ROT_L = 2'b01;
    localparam logic [1:0] CTRL_ROT_R = 2'b10;

endpackage

// File: rtl/rot_reg.sv
// Load/rotate register with no hold encoding: every clock it either loads
// data_i or rotates by one bit, as selected by {right_i, left_i}.
module rot_reg
    import rot_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  left_i,
    input  logic                  right_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] value_q;
    logic [1:0]            ctrl;

    assign ctrl = {right_i, left_i};
    assign q_o  = value_q;

    // Left moves the MSB into the LSB, right moves the LSB into the MSB.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            value_q <= '0;
        end else begin
            case (ctrl)
                CTRL_ROT_L: value_q <= {value_q[DATA_WIDTH-2:0], value_q[DATA_WIDTH-1]};
                CTRL_ROT_R: value_q <= {value_q[0], value_q[DATA_WIDTH-1:1]};
                default:    value_q <= data_i;
            endcase
        end
    end

endmodule

// File: rtl/rot_sequencer.sv
// Command-driven controller for rot_reg: loads a word, rotates it a
// programmed number of steps, and hands the result back over valid/ready.
module rot_sequencer
    import rot_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int AMT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [AMT_WIDTH-1:0]  cmd_amount,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  abort,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  busy,
    output logic                  rot_left,
    output logic                  rot_right,
    output logic [DATA_WIDTH-1:0] rot_data,
    input  logic [DATA_WIDTH-1:0] rot_q
);

    localparam logic [AMT_WIDTH-1:0] COUNT_LAST = AMT_WIDTH'(1);

    state_t                state_q;
    logic                  dir_q;
    logic [AMT_WIDTH-1:0]  amount_q;
    logic [AMT_WIDTH-1:0]  count_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            ctrl;

    // Command fields are captured here so nothing on cmd_* reaches rot_*.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_LEFT;
            amount_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        dir_q    <= cmd_dir;
                        amount_q <= cmd_amount;
                        data_q   <= cmd_data;
                        state_q  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (amount_q != '0) begin
                        count_q <= amount_q;
                        state_q <= ST_ROTATE;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                ST_ROTATE: begin
                    if (abort) begin
                        state_q <= ST_DONE;
                    end else begin
                        count_q <= count_q - COUNT_LAST;
                        if (count_q == COUNT_LAST) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // rot_reg has no hold, so every non-rotating cycle reloads its own value.
    always_comb begin
        ctrl     = CTRL_LOAD;
        rot_data = rot_q;
        case (state_q)
            ST_LOAD: rot_data = data_q;
            ST_ROTATE: begin
                if (!abort) begin
                    ctrl = (dir_q == DIR_RIGHT) ? CTRL_ROT_R : CTRL_ROT_L;
                end
            end
            default: ;
        endcase
    end

    assign rot_right = ctrl[1];
    assign rot_left  = ctrl[0];
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = rot_q;

endmodule

// File: tb/tb_rot_sequencer.sv
// Self-checking bench: rot_sequencer driving a real rot_reg, checked every
// cycle against a step-count model plus directed literal expectations.
module tb_rot_sequencer;
    import rot_pkg::*;

    localparam int W  = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_dir = 1'b0;
    logic [AW-1:0] cmd_amount = '0;
    logic [W-1:0]  cmd_data = '0;
    logic          abort = 1'b0;
    logic          res_ready = 1'b0;
    logic          cmd_ready;
    logic          res_valid;
    logic          busy;
    logic          rot_left;
    logic          rot_right;
    logic [W-1:0]  res_data;
    logic [W-1:0]  rot_data;
    logic [W-1:0]  rot_q;

    int passCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    rot_sequencer #(.DATA_WIDTH(W), .AMT_WIDTH(AW)) dut (
        .clk(clk), .n_rst(n_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_amount(cmd_amount), .cmd_data(cmd_data), .abort(abort),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .rot_left(rot_left), .rot_right(rot_right),
        .rot_data(rot_data), .rot_q(rot_q)
    );

    rot_reg #(.DATA_WIDTH(W)) regInst (
        .clk(clk), .n_rst(n_rst), .left_i(rot_left), .right_i(rot_right),
        .data_i(rot_data), .q_o(rot_q)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    // Rotation by n single-bit steps, taken as a window of the word doubled.
    function automatic logic [W-1:0] rotModel(input logic [W-1:0] x, input bit dir, input int n);
        logic [2*W-1:0] dbl;
        int s;
        dbl = {x, x};
        s = n % W;
        if (s == 0) return x;
        if (dir) return dbl[s +: W];
        return dbl[W-s +: W];
    endfunction

    // Model: a command is busy from acceptance until its result is taken;
    // one load cycle, then one rotation per cycle until the steps run out or abort.
    bit           mBusy, mLoaded, mDone, mDir;
    int           mLeft, mSteps;
    logic [W-1:0] mData, mQ;
    bit           rotating, loading;

    always @(negedge clk) begin
        if (!n_rst) begin
            mBusy = 0; mLoaded = 0; mDone = 0; mLeft = 0; mSteps = 0; mQ = '0;
        end
        rotating = mBusy && mLoaded && !mDone;
        loading  = mBusy && !mLoaded;
        checkOutput("cmd_ready", cmd_ready, !mBusy);
        checkOutput("busy", busy, mBusy);
        checkOutput("res_valid", res_valid, mDone);
        checkOutput("rot_q", rot_q, mQ);
        if (mDone) checkOutput("res_data", res_data, mQ);
        if (rotating) begin
            checkOutput("rot_left", rot_left, !abort && !mDir);
            checkOutput("rot_right", rot_right, !abort && mDir);
        end else begin
            checkOutput("rot_left idle", rot_left, 1'b0);
            checkOutput("rot_right idle", rot_right, 1'b0);
            checkOutput("rot_data", rot_data, loading ? mData : mQ);
        end
        if (n_rst) begin
            if (!mBusy) begin
                if (cmd_valid) begin
                    mBusy = 1; mLoaded = 0; mSteps = 0;
                    mDir = cmd_dir; mData = cmd_data; mLeft = int'(cmd_amount);
                end
            end else if (!mLoaded) begin
                mLoaded = 1; mQ = mData;
                if (mLeft == 0) mDone = 1;
            end else if (!mDone) begin
                if (abort) mDone = 1;
                else begin
                    mSteps++; mLeft--;
                    mQ = rotModel(mData, mDir, mSteps);
                    if (mLeft == 0) mDone = 1;
                end
            end else if (res_ready) begin
                mBusy = 0; mDone = 0;
            end
        end
    end

    // One full command: latency and result are literal expectations from the caller.
    task automatic applyStimulus(input string tag, input logic [W-1:0] data, input bit dir,
                                 input int amt, input int abortAt, input int holdCycles,
                                 input logic [W-1:0] expRes, input int expLat,
                                 input int peekLat, input logic [W-1:0] peekVal);
        int lat;
        bit seen;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_dir = dir; cmd_amount = AW'(amt); cmd_data = data;
        @(posedge clk); #1;
        cmd_valid = 0; cmd_data = ~data;
        checkOutput({tag, " accepted"}, busy, 1'b1);
        lat = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk); lat++; #1;
            if (peekLat != 0 && lat == peekLat) checkOutput({tag, " rot_q mid"}, rot_q, peekVal);
            if (res_valid) seen = 1;
            else abort = (abortAt == lat);
        end
        abort = 0;
        if (!seen) checkOutput({tag, " timeout"}, res_valid, 1'b1);
        else begin
            checkOutput({tag, " latency"}, lat, expLat);
            checkOutput({tag, " result"}, res_data, expRes);
        end
        for (int i = 0; i < holdCycles; i++) begin
            cmd_valid = (i == 1);
            cmd_data  = 4'b1111;
            @(posedge clk); #1;
            checkOutput({tag, " hold res_data"}, res_data, expRes);
            checkOutput({tag, " hold rot_q"}, rot_q, expRes);
            checkOutput({tag, " hold cmd_ready"}, cmd_ready, 1'b0);
            checkOutput({tag, " hold res_valid"}, res_valid, 1'b1);
        end
        cmd_valid = 0;
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
        checkOutput({tag, " released cmd_ready"}, cmd_ready, 1'b1);
        checkOutput({tag, " released res_valid"}, res_valid, 1'b0);
    endtask

    initial begin
        #2;
        checkOutput("reset cmd_ready", cmd_ready, 1'b1);
        checkOutput("reset res_valid", res_valid, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset rot pins", {rot_right, rot_left}, 2'b00);
        checkOutput("reset rot_data", rot_data, 4'b0000);
        checkOutput("reset res_data", res_data, 4'b0000);
        @(posedge clk); @(posedge clk); #1;
        n_rst = 1;

        applyStimulus("L1",      4'b1001, DIR_LEFT,  1, 0, 0, 4'b0011, 2, 0, 4'b0000);
        applyStimulus("R3 bp",   4'b1001, DIR_RIGHT, 3, 0, 3, 4'b0011, 4, 2, 4'b1100);
        applyStimulus("L4",      4'b1011, DIR_LEFT,  4, 0, 0, 4'b1011, 5, 0, 4'b0000);
        applyStimulus("zero",    4'b0110, DIR_LEFT,  0, 0, 0, 4'b0110, 1, 0, 4'b0000);
        applyStimulus("abort",   4'b0001, DIR_LEFT,  5, 3, 0, 4'b0100, 4, 0, 4'b0000);
        applyStimulus("R7",      4'b0110, DIR_RIGHT, 7, 0, 1, 4'b1100, 8, 0, 4'b0000);
        applyStimulus("L5",      4'b1000, DIR_LEFT,  5, 0, 0, 4'b0001, 6, 0, 4'b0000);

        @(posedge clk); #1;
        cmd_valid = 1; cmd_dir = DIR_LEFT; cmd_amount = 3'd5; cmd_data = 4'b1001;
        @(posedge clk); #1;
        cmd_valid = 0;
        repeat (2) @(posedge clk);
        #3;
        n_rst = 0;
        #1;
        checkOutput("midreset busy", busy, 1'b0);
        checkOutput("midreset res_valid", res_valid, 1'b0);
        checkOutput("midreset cmd_ready", cmd_ready, 1'b1);
        checkOutput("midreset rot pins", {rot_right, rot_left}, 2'b00);
        checkOutput("midreset rot_q", rot_q, 4'b0000);
        @(posedge clk); #1;
        n_rst = 1;
        applyStimulus("after reset", 4'b1001, DIR_LEFT, 1, 0, 0, 4'b0011, 2, 0, 4'b0000);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d passed", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
